// File: rtl/dut_uart_pkg.sv
// dut_uart_pkg: frame-state enum and framing constants shared by the DUT UART mux.
package dut_uart_pkg;
    typedef enum logic [1:0] {IDLE, HDR, PAY} frame_state_t;
    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam int UART_BITS = 10;
endpackage

// File: rtl/dut_uart_mux_if.sv
// dut_uart_mux_if: per-channel byte strobes and data lanes from the DUT copies.
interface dut_uart_mux_if #(parameter int NUM_CH = 2) ();
    logic [NUM_CH-1:0]   byte_en;
    logic [NUM_CH*8-1:0] byte_data;
    modport master (output byte_en, byte_data);
    modport slave  (input  byte_en, byte_data);
endinterface

// File: rtl/dut_uart_fifo.sv
// dut_uart_fifo: single-clock show-ahead FIFO; a push on full is kept when a pop happens in the same cycle.
module dut_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             drop
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full, wr, rd;
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rd    = pop && !empty;
    assign wr    = push && (!full || rd);
    assign drop  = push && full && !rd;
    assign dout  = mem[rp[AW-1:0]];
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            wp <= wr ? wp + 1'b1 : wp;
            rp <= rd ? rp + 1'b1 : rp;
        end
    end
    always_ff @(posedge clk)
        if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/dut_uart_mux.sv
// dut_uart_mux: round-robin merge of NUM_CH byte streams into tagged 2-char 8N1 frames on one TX pin.
// Optional lockstep comparator on the input strobes/lanes is enabled by defining DUT_CMP_EN.
module dut_uart_mux
    import dut_uart_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               resetn,
    dut_uart_mux_if.slave      bus,
    output logic               uart_txd_o,
    output logic               busy_o,
    output logic [NUM_CH-1:0]  overflow_o,
    output logic               mismatch_o
);
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW:0]   NCH  = (CW+1)'(NUM_CH);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    frame_state_t      state, state_n;
    logic [CW-1:0]     rr, gnt;
    logic [CW:0]       j;
    logic              gnt_v, take, char_done;
    logic [NUM_CH-1:0] empty, drop, pop;
    logic [7:0]        dout [NUM_CH];
    logic [7:0]        payload;
    logic [8:0]        sh;
    logic [3:0]        bit_cnt;
    logic [BW-1:0]     clk_cnt;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dut_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk(clk), .resetn(resetn), .push(bus.byte_en[c]), .pop(pop[c]),
            .din(bus.byte_data[8*c +: 8]), .dout(dout[c]), .empty(empty[c]), .drop(drop[c])
        );
        assign pop[c] = take && gnt == CW'(c);
    end

    assign char_done = state != IDLE && clk_cnt == LAST && bit_cnt == 4'(UART_BITS - 1);
    // a grant may also land on the last stop-bit cycle of the payload, giving back-to-back frames
    assign take = gnt_v && (state == IDLE || (state == PAY && char_done));

    always_comb begin
        gnt   = '0;
        gnt_v = 1'b0;
        j     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            j = {1'b0, rr} + (CW+1)'(i);
            j = j >= NCH ? j - NCH : j;
            if (!empty[j[CW-1:0]]) begin
                gnt   = j[CW-1:0];
                gnt_v = 1'b1;
            end
        end
        state_n = take ? HDR : char_done ? (state == HDR ? PAY : IDLE) : state;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            rr         <= '0;
            payload    <= '0;
            sh         <= '1;
            bit_cnt    <= '0;
            clk_cnt    <= '0;
            uart_txd_o <= 1'b1;
            busy_o     <= 1'b0;
            overflow_o <= '0;
        end else begin
            state      <= state_n;
            busy_o     <= (|(~empty)) | (state_n != IDLE);
            overflow_o <= overflow_o | drop;
            if (take) begin
                rr         <= gnt == CW'(NUM_CH - 1) ? '0 : gnt + 1'b1;
                payload    <= dout[gnt];
                sh         <= {1'b1, HDR_TAG, 4'(gnt)};
                uart_txd_o <= 1'b0;
                bit_cnt    <= '0;
                clk_cnt    <= '0;
            end else if (state == HDR && char_done) begin
                sh         <= {1'b1, payload};
                uart_txd_o <= 1'b0;
                bit_cnt    <= '0;
                clk_cnt    <= '0;
            end else if (state != IDLE) begin
                if (clk_cnt == LAST) begin
                    clk_cnt    <= '0;
                    bit_cnt    <= bit_cnt + 1'b1;
                    uart_txd_o <= sh[0];
                    sh         <= {1'b1, sh[8:1]};
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end
            end
        end
    end

`ifdef DUT_CMP_EN
    logic mis_set;
    always_comb begin
        mis_set = 1'b0;
        if (NUM_CH > 1) begin
            mis_set = bus.byte_en != '0 && bus.byte_en != '1;
            for (int i = 1; i < NUM_CH; i++)
                if (&bus.byte_en && bus.byte_data[8*i +: 8] != bus.byte_data[7:0]) mis_set = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) mismatch_o <= 1'b0;
        else         mismatch_o <= mismatch_o | mis_set;
`else
    assign mismatch_o = 1'b0;
`endif
endmodule
